// File: rtl/drm_uip_arbiter_if.sv
// Stream bundle between four user IPs, the arbiter and the DRM controller user-IP port.
// The slave modport is the arbiter's view and the master modport is the surrounding system's view.
interface drm_uip_arbiter_if #(
    parameter int unsigned C_DATA_WIDTH = 32
);
    logic [3:0]                uip_to_arb_tvalid;
    logic [4*C_DATA_WIDTH-1:0] uip_to_arb_tdata;
    logic [3:0]                uip_to_arb_tready;

    logic                      arb_to_drm_tvalid;
    logic [C_DATA_WIDTH-1:0]   arb_to_drm_tdata;
    logic                      arb_to_drm_tready;

    logic                      drm_to_arb_tvalid;
    logic [C_DATA_WIDTH-1:0]   drm_to_arb_tdata;
    logic                      drm_to_arb_tready;

    logic [3:0]                arb_to_uip_tvalid;
    logic [4*C_DATA_WIDTH-1:0] arb_to_uip_tdata;
    logic [3:0]                arb_to_uip_tready;

    modport slave (
        input  uip_to_arb_tvalid, uip_to_arb_tdata, arb_to_drm_tready,
        input  drm_to_arb_tvalid, drm_to_arb_tdata, arb_to_uip_tready,
        output uip_to_arb_tready, arb_to_drm_tvalid, arb_to_drm_tdata,
        output drm_to_arb_tready, arb_to_uip_tvalid, arb_to_uip_tdata
    );

    modport master (
        output uip_to_arb_tvalid, uip_to_arb_tdata, arb_to_drm_tready,
        output drm_to_arb_tvalid, drm_to_arb_tdata, arb_to_uip_tready,
        input  uip_to_arb_tready, arb_to_drm_tvalid, arb_to_drm_tdata,
        input  drm_to_arb_tready, arb_to_uip_tvalid, arb_to_uip_tdata
    );
endinterface

// File: rtl/drm_uip_arbiter.sv
// Round-robin arbiter that shares one DRM controller user-IP port among 4 IPs, one frame at a time.
// The optional response watchdog is built only when DRM_ARB_TIMEOUT_EN is defined.
module drm_uip_arbiter #(
    parameter int unsigned C_DATA_WIDTH     = 32,
    parameter int unsigned C_FRAME_WORDS    = 4,
    parameter int unsigned C_TIMEOUT_CYCLES = 1024
) (
    input  logic             ap_clk,
    input  logic             ap_rst_n,
    drm_uip_arbiter_if.slave bus,
    output logic [1:0]       grant_id,
    output logic             busy,
    output logic             timeout_err
);
    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, RSP = 2'd2} state_t;

    localparam logic [7:0] LAST_WORD = 8'(C_FRAME_WORDS - 1);

    if (C_FRAME_WORDS < 2 || C_FRAME_WORDS > 255 ||
        C_TIMEOUT_CYCLES < 1 || C_TIMEOUT_CYCLES > 65535) begin : g_param_check
        $error("drm_uip_arbiter: parameter out of range");
    end

    state_t     state_q, state_d;
    logic [7:0] word_cnt_q, word_cnt_d;
    logic [1:0] grant_d, last_q, last_d, winner, idx;
    logic       win_vld, req_hs, rsp_hs, last_word;

    assign req_hs    = (state_q == REQ) && bus.uip_to_arb_tvalid[grant_id] && bus.arb_to_drm_tready;
    assign rsp_hs    = (state_q == RSP) && bus.drm_to_arb_tvalid && bus.arb_to_uip_tready[grant_id];
    assign last_word = (word_cnt_q == LAST_WORD);
    assign busy      = (state_q != IDLE);

    // Search starts one past the last served IP; k == 4 wraps back onto it.
    always_comb begin
        winner  = last_q;
        win_vld = 1'b0;
        idx     = last_q;
        for (int unsigned k = 1; k <= 4; k++) begin
            idx = last_q + k[1:0];
            if (!win_vld && bus.uip_to_arb_tvalid[idx]) begin
                winner  = idx;
                win_vld = 1'b1;
            end
        end
    end

`ifdef DRM_ARB_TIMEOUT_EN
    localparam logic [15:0] TMO_LAST = 16'(C_TIMEOUT_CYCLES - 1);

    logic [15:0] wd_q;
    logic        wd_expire;

    assign wd_expire = (state_q == RSP) && !rsp_hs && (wd_q == TMO_LAST);

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            wd_q        <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (state_q == RSP && !rsp_hs && !wd_expire) begin
                wd_q <= wd_q + 16'd1;
            end else begin
                wd_q <= '0;
            end
            if (wd_expire) begin
                timeout_err <= 1'b1;
            end
        end
    end
`else
    assign timeout_err = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        word_cnt_d = word_cnt_q;
        grant_d    = grant_id;
        last_d     = last_q;
        case (state_q)
            IDLE: begin
                if (win_vld) begin
                    grant_d = winner;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (req_hs) begin
                    if (last_word) begin
                        word_cnt_d = '0;
                        state_d    = RSP;
                    end else begin
                        word_cnt_d = word_cnt_q + 8'd1;
                    end
                end
            end
            RSP: begin
                if (rsp_hs) begin
                    if (last_word) begin
                        word_cnt_d = '0;
                        state_d    = IDLE;
                        last_d     = grant_id;
                    end else begin
                        word_cnt_d = word_cnt_q + 8'd1;
                    end
                end
`ifdef DRM_ARB_TIMEOUT_EN
                else if (wd_expire) begin
                    word_cnt_d = '0;
                    state_d    = IDLE;
                    last_d     = grant_id;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q    <= IDLE;
            word_cnt_q <= '0;
            grant_id   <= '0;
            last_q     <= 2'd3;
        end else begin
            state_q    <= state_d;
            word_cnt_q <= word_cnt_d;
            grant_id   <= grant_d;
            last_q     <= last_d;
        end
    end

    // Zero-latency routing; only the granted lane ever sees valid/ready.
    always_comb begin
        bus.uip_to_arb_tready = '0;
        bus.arb_to_drm_tvalid = 1'b0;
        bus.arb_to_drm_tdata  = bus.uip_to_arb_tdata[grant_id*C_DATA_WIDTH +: C_DATA_WIDTH];
        bus.drm_to_arb_tready = 1'b0;
        bus.arb_to_uip_tvalid = '0;
        bus.arb_to_uip_tdata  = {4{bus.drm_to_arb_tdata}};
        if (state_q == REQ) begin
            bus.arb_to_drm_tvalid           = bus.uip_to_arb_tvalid[grant_id];
            bus.uip_to_arb_tready[grant_id] = bus.arb_to_drm_tready;
        end
        if (state_q == RSP) begin
            bus.arb_to_uip_tvalid[grant_id] = bus.drm_to_arb_tvalid;
            bus.drm_to_arb_tready           = bus.arb_to_uip_tready[grant_id];
        end
    end
endmodule

// File: tb/tb_drm_uip_arbiter.sv
// Randomized self-checking bench for drm_uip_arbiter against a frame-level round-robin model.
// The watchdog scenario follows DRM_ARB_TIMEOUT_EN, matching the DUT build.
module tb_drm_uip_arbiter;
    localparam int unsigned W   = 32;
    localparam int unsigned F   = 4;
    localparam int unsigned TMO = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [1:0] grant_id;
    logic       busy, timeout_err;

    drm_uip_arbiter_if #(.C_DATA_WIDTH(W)) bus ();

    drm_uip_arbiter #(
        .C_DATA_WIDTH(W), .C_FRAME_WORDS(F), .C_TIMEOUT_CYCLES(TMO)
    ) dut (
        .ap_clk(clk), .ap_rst_n(rst_n), .bus(bus),
        .grant_id(grant_id), .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int unsigned n_tests = 0, n_fail = 0;
    int unsigned req_rdy_pct, uip_rdy_pct, rsp_vld_pct, viol, model_last;
    bit          rsp_en;

    logic [W-1:0] src_q   [4][$];
    logic [W-1:0] exp_req [4][$];
    logic [W-1:0] rsp_q [$];
    logic [W-1:0] rsp_all [$];
    logic [W-1:0] req_log [$];
    logic [1:0]   gnt_log [$];
    logic [W-1:0] rsp_log [4][$];
    logic [W-1:0] exp_stream [$];
    logic [1:0]   exp_gnt [$];
    logic [1:0]   exp_order [$];
    logic [W-1:0] exp_rsp [4][$];

    task automatic idle_inputs();
        bus.uip_to_arb_tvalid = '0;
        bus.uip_to_arb_tdata  = '0;
        bus.arb_to_drm_tready = 1'b0;
        bus.drm_to_arb_tvalid = 1'b0;
        bus.drm_to_arb_tdata  = '0;
        bus.arb_to_uip_tready = '0;
    endtask

    task automatic clear_all();
        for (int unsigned i = 0; i < 4; i++) begin
            src_q[i].delete(); exp_req[i].delete(); rsp_log[i].delete(); exp_rsp[i].delete();
        end
        rsp_q.delete(); rsp_all.delete(); req_log.delete(); gnt_log.delete();
        exp_stream.delete(); exp_gnt.delete(); exp_order.delete();
        viol = 0; model_last = 3;
        req_rdy_pct = 100; uip_rdy_pct = 100; rsp_vld_pct = 100; rsp_en = 1'b1;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        idle_inputs();
        clear_all();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic add_frame(input int unsigned ip);
        logic [W-1:0] w;
        for (int unsigned j = 0; j < F; j++) begin
            w = $urandom;
            src_q[ip].push_back(w);
            exp_req[ip].push_back(w);
        end
    endtask

    task automatic add_rsp(input int unsigned frames);
        logic [W-1:0] w;
        for (int unsigned j = 0; j < frames * F; j++) begin
            w = $urandom;
            rsp_q.push_back(w);
            rsp_all.push_back(w);
        end
    endtask

    // Frame-level model: whenever the channel is free, the next IP with frames left after the last served one wins.
    task automatic model_schedule();
        int unsigned pend [4];
        int unsigned total, pick;
        total = 0;
        for (int unsigned i = 0; i < 4; i++) begin
            pend[i] = exp_req[i].size() / F;
            total += pend[i];
        end
        while (total > 0) begin
            pick = 0;
            for (int unsigned k = 1; k <= 4; k++) begin
                if (pend[(model_last + k) % 4] > 0) begin
                    pick = (model_last + k) % 4;
                    break;
                end
            end
            exp_order.push_back(pick[1:0]);
            pend[pick]--; total--; model_last = pick;
            for (int unsigned j = 0; j < F; j++) begin
                exp_stream.push_back(exp_req[pick].pop_front());
                exp_gnt.push_back(pick[1:0]);
            end
        end
        for (int unsigned f = 0; f < exp_order.size(); f++)
            for (int unsigned j = 0; j < F; j++)
                if (f * F + j < rsp_all.size()) exp_rsp[exp_order[f]].push_back(rsp_all[f * F + j]);
    endtask

    function automatic int unsigned rsp_total();
        return rsp_log[0].size() + rsp_log[1].size() + rsp_log[2].size() + rsp_log[3].size();
    endfunction

    // One clock: drive at negedge, sample settled outputs 1 time unit later, then cross the posedge.
    task automatic step();
        @(negedge clk);
        for (int unsigned i = 0; i < 4; i++) begin
            bus.uip_to_arb_tvalid[i] = (src_q[i].size() > 0);
            bus.uip_to_arb_tdata[i*W +: W] = (src_q[i].size() > 0) ? src_q[i][0] : W'($urandom);
            bus.arb_to_uip_tready[i] = ($urandom_range(99) < uip_rdy_pct);
        end
        bus.arb_to_drm_tready = ($urandom_range(99) < req_rdy_pct);
        bus.drm_to_arb_tvalid = rsp_en && (rsp_q.size() > 0) && ($urandom_range(99) < rsp_vld_pct);
        bus.drm_to_arb_tdata  = (rsp_q.size() > 0) ? rsp_q[0] : '0;
        #1;
        if ((bus.uip_to_arb_tready & ~(4'b1 << grant_id)) != 4'b0) viol++;
        if ((bus.arb_to_uip_tvalid & ~(4'b1 << grant_id)) != 4'b0) viol++;
        if (bus.arb_to_drm_tvalid && bus.drm_to_arb_tready) viol++;
        if (bus.arb_to_drm_tvalid && bus.arb_to_drm_tready) begin
            req_log.push_back(bus.arb_to_drm_tdata);
            gnt_log.push_back(grant_id);
        end
        for (int unsigned i = 0; i < 4; i++) begin
            if (bus.uip_to_arb_tvalid[i] && bus.uip_to_arb_tready[i]) void'(src_q[i].pop_front());
            if (bus.arb_to_uip_tvalid[i] && bus.arb_to_uip_tready[i])
                rsp_log[i].push_back(bus.arb_to_uip_tdata[i*W +: W]);
        end
        if (bus.drm_to_arb_tvalid && bus.drm_to_arb_tready) void'(rsp_q.pop_front());
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus.uip_to_arb_tvalid = 4'hF;
        bus.arb_to_drm_tready = 1'b1;
        bus.drm_to_arb_tvalid = 1'b1;
        bus.arb_to_uip_tready = 4'hF;
        #2 rst_n = 1'b0;
        #1;
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b expected 0", busy); end
        n_tests++; if (grant_id !== 2'd0) begin n_fail++; $display("FAIL reset_grant: got %0d expected 0", grant_id); end
        n_tests++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL reset_tmo: got %0b expected 0", timeout_err); end
        n_tests++; if (bus.uip_to_arb_tready !== 4'h0) begin n_fail++; $display("FAIL reset_uip_tready: got %0h expected 0", bus.uip_to_arb_tready); end
        n_tests++; if ({bus.arb_to_drm_tvalid, bus.drm_to_arb_tready} !== 2'b00) begin n_fail++; $display("FAIL reset_drm_side: got %0b expected 0", {bus.arb_to_drm_tvalid, bus.drm_to_arb_tready}); end
        n_tests++; if (bus.arb_to_uip_tvalid !== 4'h0) begin n_fail++; $display("FAIL reset_uip_tvalid: got %0h expected 0", bus.arb_to_uip_tvalid); end
        apply_reset();
    endtask

    task automatic test_single_ip2();
        apply_reset();
        add_frame(2); add_rsp(1); model_schedule();
        step();
        n_tests++; if (grant_id !== 2'd2 || busy !== 1'b1) begin n_fail++; $display("FAIL ip2_grant: got grant=%0d busy=%0b expected grant=2 busy=1", grant_id, busy); end
        repeat (F) step();
        n_tests++; if (req_log.size() != F) begin n_fail++; $display("FAIL ip2_req_count: got %0d expected %0d", req_log.size(), F); end
        for (int unsigned j = 0; j < F && j < req_log.size(); j++) begin
            n_tests++; if (req_log[j] !== exp_stream[j]) begin n_fail++; $display("FAIL ip2_req_word%0d: got %0h expected %0h", j, req_log[j], exp_stream[j]); end
        end
        repeat (F) step();
        n_tests++; if (rsp_log[2].size() != F || rsp_total() != F) begin n_fail++; $display("FAIL ip2_rsp_count: got ip2=%0d total=%0d expected %0d", rsp_log[2].size(), rsp_total(), F); end
        for (int unsigned j = 0; j < F && j < rsp_log[2].size(); j++) begin
            n_tests++; if (rsp_log[2][j] !== exp_rsp[2][j]) begin n_fail++; $display("FAIL ip2_rsp_word%0d: got %0h expected %0h", j, rsp_log[2][j], exp_rsp[2][j]); end
        end
        n_tests++; if (busy !== 1'b0 || viol != 0) begin n_fail++; $display("FAIL ip2_end: got busy=%0b viol=%0d expected 0 0", busy, viol); end
    endtask

    task automatic test_round_robin();
        apply_reset();
        for (int unsigned i = 0; i < 4; i++) begin add_frame(i); add_frame(i); end
        add_rsp(8); model_schedule();
        repeat (5 * (2 * F + 1)) step();
        n_tests++; if (req_log.size() != 5 * F || rsp_total() != 5 * F || busy !== 1'b0) begin n_fail++; $display("FAIL rr_timing: got req=%0d rsp=%0d busy=%0b expected %0d %0d 0", req_log.size(), rsp_total(), busy, 5 * F, 5 * F); end
        for (int unsigned f = 0; f < 5 && (f + 1) * F <= gnt_log.size(); f++) begin
            n_tests++; if (gnt_log[f * F] !== exp_order[f]) begin n_fail++; $display("FAIL rr_order%0d: got %0d expected %0d", f, gnt_log[f * F], exp_order[f]); end
        end
        for (int unsigned j = 0; j < req_log.size() && j < 5 * F; j++) begin
            n_tests++; if (req_log[j] !== exp_stream[j]) begin n_fail++; $display("FAIL rr_word%0d: got %0h expected %0h", j, req_log[j], exp_stream[j]); end
        end
        n_tests++; if (viol != 0) begin n_fail++; $display("FAIL rr_routing: got %0d violations expected 0", viol); end
    endtask

    task automatic test_backpressure();
        int unsigned pattern [7] = '{100, 100, 0, 0, 0, 100, 100};
        apply_reset();
        add_frame(0); add_rsp(1); model_schedule();
        step();
        for (int unsigned t = 0; t < 7; t++) begin
            req_rdy_pct = pattern[t];
            step();
            if (t == 4) begin
                n_tests++; if (req_log.size() != 2 || busy !== 1'b1 || bus.drm_to_arb_tready !== 1'b0) begin n_fail++; $display("FAIL bp_hold: got words=%0d busy=%0b rsp_rdy=%0b expected 2 1 0", req_log.size(), busy, bus.drm_to_arb_tready); end
            end
        end
        n_tests++; if (req_log.size() != F) begin n_fail++; $display("FAIL bp_count: got %0d expected %0d", req_log.size(), F); end
        for (int unsigned j = 0; j < req_log.size() && j < F; j++) begin
            n_tests++; if (req_log[j] !== exp_stream[j]) begin n_fail++; $display("FAIL bp_word%0d: got %0h expected %0h", j, req_log[j], exp_stream[j]); end
        end
        repeat (F) step();
        n_tests++; if (rsp_log[0].size() != F || busy !== 1'b0) begin n_fail++; $display("FAIL bp_rsp: got %0d busy=%0b expected %0d 0", rsp_log[0].size(), busy, F); end
    endtask

    task automatic test_random(input int unsigned rounds);
        int unsigned frames, total;
        for (int unsigned r = 0; r < rounds; r++) begin
            apply_reset();
            req_rdy_pct = $urandom_range(30, 100);
            uip_rdy_pct = $urandom_range(30, 100);
            rsp_vld_pct = $urandom_range(30, 100);
            total = 0;
            for (int unsigned i = 0; i < 4; i++) begin
                frames = $urandom_range(0, 3);
                if (i == 3 && total == 0) frames = 1;
                for (int unsigned f = 0; f < frames; f++) add_frame(i);
                total += frames;
            end
            add_rsp(total); model_schedule();
            for (int unsigned t = 0; t < 4000 && rsp_total() < total * F; t++) step();
            n_tests++; if (rsp_total() != total * F || req_log.size() != total * F) begin n_fail++; $display("FAIL rand%0d_done: got req=%0d rsp=%0d expected %0d", r, req_log.size(), rsp_total(), total * F); end
            for (int unsigned j = 0; j < req_log.size() && j < exp_stream.size(); j++) begin
                n_tests++; if (req_log[j] !== exp_stream[j] || gnt_log[j] !== exp_gnt[j]) begin n_fail++; $display("FAIL rand%0d_req%0d: got %0h/ip%0d expected %0h/ip%0d", r, j, req_log[j], gnt_log[j], exp_stream[j], exp_gnt[j]); end
            end
            for (int unsigned i = 0; i < 4; i++) begin
                n_tests++; if (rsp_log[i] != exp_rsp[i]) begin n_fail++; $display("FAIL rand%0d_rsp_ip%0d: got %0d words expected %0d words (content differs)", r, i, rsp_log[i].size(), exp_rsp[i].size()); end
            end
            n_tests++; if (viol != 0) begin n_fail++; $display("FAIL rand%0d_routing: got %0d violations expected 0", r, viol); end
        end
    endtask

    task automatic test_reset_midframe();
        int unsigned hs_before;
        apply_reset();
        add_frame(0); add_rsp(1);
        repeat (2 * F + 1) step();
        add_frame(1); add_frame(0);
        step();
        n_tests++; if (grant_id !== 2'd1) begin n_fail++; $display("FAIL mid_pre_grant: got %0d expected 1", grant_id); end
        repeat (2) step();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_tests++; if ({busy, grant_id, bus.arb_to_drm_tvalid, bus.uip_to_arb_tready, bus.drm_to_arb_tready, bus.arb_to_uip_tvalid} !== 13'b0) begin n_fail++; $display("FAIL mid_async_clear: got busy=%0b grant=%0d drm_v=%0b uip_r=%0h", busy, grant_id, bus.arb_to_drm_tvalid, bus.uip_to_arb_tready); end
        hs_before = req_log.size();
        repeat (2) step();
        n_tests++; if (req_log.size() != hs_before) begin n_fail++; $display("FAIL mid_no_hs: got %0d words expected %0d", req_log.size(), hs_before); end
        clear_all();
        rst_n = 1'b1;
        add_frame(0); add_frame(1); add_rsp(2); model_schedule();
        step();
        n_tests++; if (grant_id !== exp_order[0]) begin n_fail++; $display("FAIL mid_post_grant: got %0d expected %0d", grant_id, exp_order[0]); end
        repeat (F) step();
        n_tests++; if (req_log.size() != F || req_log[0] !== exp_stream[0]) begin n_fail++; $display("FAIL mid_post_frame: got %0d words expected %0d", req_log.size(), F); end
    endtask

`ifdef DRM_ARB_TIMEOUT_EN
    task automatic test_timeout();
        int unsigned rsp_cycles;
        apply_reset();
        rsp_en = 1'b0;
        add_frame(0);
        repeat (F + 1) step();
        rsp_cycles = 0;
        for (int unsigned t = 0; t < 100 && busy; t++) begin
            if (bus.drm_to_arb_tready) rsp_cycles++;
            step();
        end
        n_tests++; if (rsp_cycles != TMO || busy !== 1'b0) begin n_fail++; $display("FAIL tmo_cycles: got %0d busy=%0b expected %0d 0", rsp_cycles, busy, TMO); end
        n_tests++; if (timeout_err !== 1'b1) begin n_fail++; $display("FAIL tmo_flag: got %0b expected 1", timeout_err); end
        rsp_en = 1'b1;
        add_frame(0); add_frame(1); add_rsp(1);
        step();
        n_tests++; if (grant_id !== 2'd1) begin n_fail++; $display("FAIL tmo_next_grant: got %0d expected 1", grant_id); end
        repeat (2 * F) step();
        n_tests++; if (rsp_log[1].size() != F || rsp_log[1][0] !== rsp_all[0] || busy !== 1'b0) begin n_fail++; $display("FAIL tmo_next_frame: got %0d rsp busy=%0b expected %0d 0", rsp_log[1].size(), busy, F); end
        n_tests++; if (timeout_err !== 1'b1) begin n_fail++; $display("FAIL tmo_sticky: got %0b expected 1", timeout_err); end
    endtask
`else
    task automatic test_timeout();
        apply_reset();
        rsp_en = 1'b0;
        add_frame(0); add_rsp(1);
        repeat (F + 1 + 3 * TMO) step();
        n_tests++; if (busy !== 1'b1 || bus.drm_to_arb_tready !== 1'b1 || timeout_err !== 1'b0) begin n_fail++; $display("FAIL wait_rsp: got busy=%0b rdy=%0b tmo=%0b expected 1 1 0", busy, bus.drm_to_arb_tready, timeout_err); end
        rsp_en = 1'b1;
        repeat (F) step();
        n_tests++; if (rsp_log[0].size() != F || busy !== 1'b0) begin n_fail++; $display("FAIL wait_rsp_done: got %0d busy=%0b expected %0d 0", rsp_log[0].size(), busy, F); end
    endtask
`endif

    initial begin
        idle_inputs();
        clear_all();
        test_reset();
        test_single_ip2();
        test_round_robin();
        test_backpressure();
        test_random(4);
        test_reset_midframe();
        test_timeout();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
